// File: rtl/xain_pkg.sv
// Shared types and constants for the XSleena core.
// Holds the SDRAM channel 3 arbiter state, owner and watchdog width.
package xain_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_DONE
    } ch3_arb_state_t;

    typedef enum logic {
        OWN_ROM,
        OWN_BG2
    } ch3_owner_t;

    localparam int CH3_WD_W = 10;

endpackage

// File: rtl/sdr_ch3_arbiter.sv
// SDRAM channel 3 arbiter: ROM-download writes versus BG2 tile reads, with
// registered grant, null completion of BG2 during download and an access watchdog.
module sdr_ch3_arbiter
    import xain_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rom_mode,
    input  logic        rom_req,
    input  logic [24:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic [1:0]  rom_be,
    output logic        rom_rdy,
    input  logic        bg2_req,
    input  logic [24:0] bg2_addr,
    output logic [15:0] bg2_dout,
    output logic        bg2_rdy,
    output logic        ch3_req,
    output logic [23:0] ch3_addr,
    output logic [15:0] ch3_din,
    output logic [1:0]  ch3_be,
    output logic        ch3_rnw,
    input  logic [15:0] ch3_dout,
    input  logic        ch3_ready,
    output logic        busy,
    output logic        timeout
);

    localparam logic [CH3_WD_W-1:0] WD_LAST = CH3_WD_W'(TIMEOUT_CYCLES - 1);

    ch3_arb_state_t      r_state;
    ch3_arb_state_t      w_stateNext;
    ch3_owner_t          r_owner;
    logic [CH3_WD_W-1:0] r_wd;
    logic                r_romRdy;
    logic                r_bg2Rdy;
    logic [15:0]         r_bg2Dout;
    logic                r_ch3Req;
    logic [23:0]         r_ch3Addr;
    logic [15:0]         r_ch3Din;
    logic [1:0]          r_ch3Be;
    logic                r_ch3Rnw;
    logic                r_busy;
    logic                r_timeout;
    logic                r_nullPulse;

    logic w_grantRom;
    logic w_grantBg2;
    logic w_finish;
    logic w_expire;
    logic w_bg2Served;
    logic w_nullFire;
    logic w_unused;

    // Byte address bit 0 has no meaning on the 16-bit SDRAM word bus.
    assign w_unused = rom_addr[0] ^ bg2_addr[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_grantRom  = 1'b0;
        w_grantBg2  = 1'b0;
        w_finish    = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (rom_req && rom_mode) begin
                    w_grantRom  = 1'b1;
                    w_stateNext = ARB_ISSUE;
                end else if (bg2_req && !rom_mode) begin
                    w_grantBg2  = 1'b1;
                    w_stateNext = ARB_ISSUE;
                end
            end
            // A ready arriving on the expiry cycle wins: it is a normal completion.
            ARB_ISSUE: begin
                if (ch3_ready) begin
                    w_finish    = 1'b1;
                    w_stateNext = ARB_DONE;
                end else if (r_wd == WD_LAST) begin
                    w_finish    = 1'b1;
                    w_expire    = 1'b1;
                    w_stateNext = ARB_DONE;
                end
            end
            ARB_DONE: begin
                w_stateNext = ARB_IDLE;
            end
            default: begin
                w_stateNext = ARB_IDLE;
            end
        endcase
    end

    assign w_bg2Served = (r_state != ARB_IDLE) && (r_owner == OWN_BG2);
    assign w_nullFire  = rom_mode && bg2_req && !w_bg2Served && !r_nullPulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= OWN_ROM;
            r_wd        <= '0;
            r_romRdy    <= 1'b0;
            r_bg2Rdy    <= 1'b0;
            r_bg2Dout   <= 16'h0000;
            r_ch3Req    <= 1'b0;
            r_ch3Addr   <= 24'h000000;
            r_ch3Din    <= 16'h0000;
            r_ch3Be     <= 2'b00;
            r_ch3Rnw    <= 1'b1;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
            r_nullPulse <= 1'b0;
        end else begin
            r_romRdy    <= 1'b0;
            r_bg2Rdy    <= 1'b0;
            r_nullPulse <= w_nullFire;

            if (w_grantRom) begin
                r_owner   <= OWN_ROM;
                r_ch3Addr <= rom_addr[24:1];
                r_ch3Din  <= rom_data;
                r_ch3Be   <= rom_be;
                r_ch3Rnw  <= 1'b0;
                r_ch3Req  <= 1'b1;
                r_busy    <= 1'b1;
                r_wd      <= '0;
            end else if (w_grantBg2) begin
                r_owner   <= OWN_BG2;
                r_ch3Addr <= bg2_addr[24:1];
                r_ch3Din  <= 16'h0000;
                r_ch3Be   <= 2'b11;
                r_ch3Rnw  <= 1'b1;
                r_ch3Req  <= 1'b1;
                r_busy    <= 1'b1;
                r_wd      <= '0;
            end

            if (r_state == ARB_ISSUE) begin
                r_wd <= r_wd + 1'b1;
            end

            if (w_finish) begin
                r_ch3Req <= 1'b0;
                if (r_owner == OWN_BG2) begin
                    r_bg2Rdy  <= 1'b1;
                    r_bg2Dout <= w_expire ? 16'hFFFF : ch3_dout;
                end else begin
                    r_romRdy <= 1'b1;
                end
                if (w_expire) begin
                    r_timeout <= 1'b1;
                end
            end

            // Download-time BG2 reads complete with zero data, never touching SDRAM.
            if (w_nullFire) begin
                r_bg2Rdy  <= 1'b1;
                r_bg2Dout <= 16'h0000;
            end

            if (r_state == ARB_DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign rom_rdy  = r_romRdy;
    assign bg2_rdy  = r_bg2Rdy;
    assign bg2_dout = r_bg2Dout;
    assign ch3_req  = r_ch3Req;
    assign ch3_addr = r_ch3Addr;
    assign ch3_din  = r_ch3Din;
    assign ch3_be   = r_ch3Be;
    assign ch3_rnw  = r_ch3Rnw;
    assign busy     = r_busy;
    assign timeout  = r_timeout;

endmodule
